// File: rtl/fft_stage_sched_if.sv
// Sequencer-to-datapath bus for the in-place radix-2 FFT scheduler.
// master = scheduler side (drives addresses/strobes), slave = controller/datapath side.
interface fft_stage_sched_if #(
  parameter int unsigned N_SAMPLES = 8
);
  localparam int unsigned A  = $clog2(N_SAMPLES);
  localparam int unsigned TW = A - 1;

  logic          start;
  logic          busy;
  logic          done;
  logic [A-1:0]  stage;
  logic          rd_en;
  logic [A-1:0]  rd_addr1;
  logic [A-1:0]  rd_addr2;
  logic [TW-1:0] tw_addr;
  logic          wr_en;
  logic [A-1:0]  wr_addr1;
  logic [A-1:0]  wr_addr2;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr1, rd_addr2, tw_addr,
           wr_en, wr_addr1, wr_addr2
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr1, rd_addr2, tw_addr,
           wr_en, wr_addr1, wr_addr2
  );
endinterface

// File: rtl/fft_stage_sched.sv
// In-place radix-2 DIT FFT sequencer: one butterfly read per cycle, write-back
// BFLY_LAT cycles later, with a drain gap between stages.
module fft_stage_sched #(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned BFLY_LAT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_stage_sched_if.master  bus
);

  localparam int unsigned A  = $clog2(N_SAMPLES);
  localparam int unsigned S  = A;
  localparam int unsigned BW = A - 1;
  localparam int unsigned TW = A - 1;
  localparam int unsigned DW = $clog2(BFLY_LAT + 1);

  localparam logic [BW-1:0] B_LAST = BW'(N_SAMPLES / 2 - 1);
  localparam logic [A-1:0]  S_LAST = A'(S - 1);
  localparam logic [DW-1:0] D_INIT = DW'(BFLY_LAT);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic         en;
    logic [A-1:0] a1;
    logic [A-1:0] a2;
  } wr_slot_t;

  state_e         state_q;
  logic [BW-1:0]  b_q;
  logic [A-1:0]   stage_q;
  logic [DW-1:0]  drain_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_en_q;
  logic [A-1:0]   rd_addr1_q;
  logic [A-1:0]   rd_addr2_q;
  logic [TW-1:0]  tw_addr_q;
  wr_slot_t       pipe_q [BFLY_LAT];

  logic [BW-1:0]  issue_b_c;
  logic [A-1:0]   issue_s_c;
  logic [A-1:0]   half_c;
  logic [A-1:0]   pos_c;
  logic [A-1:0]   group_c;
  logic [A-1:0]   a1_c;
  logic [A-1:0]   a2_c;
  logic [TW-1:0]  tw_c;

  // Butterfly/stage pair that the next issue cycle will present, and its addresses.
  always_comb begin
    issue_b_c = '0;
    issue_s_c = stage_q;
    unique case (state_q)
      IDLE:    issue_s_c = '0;
      ISSUE:   issue_b_c = b_q + BW'(1);
      DRAIN:   issue_s_c = stage_q + A'(1);
      default: issue_s_c = '0;
    endcase

    half_c  = A'(1) << issue_s_c;
    pos_c   = A'(issue_b_c) & (half_c - A'(1));
    group_c = A'(issue_b_c) >> issue_s_c;
    a1_c    = ((group_c << 1) << issue_s_c) | pos_c;
    a2_c    = a1_c + half_c;
    tw_c    = TW'(pos_c << (A'(A - 1) - issue_s_c));
  end

  // Stage/butterfly walker with drain gap between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b_q        <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      tw_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ISSUE;
            b_q        <= '0;
            stage_q    <= '0;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            rd_addr1_q <= a1_c;
            rd_addr2_q <= a2_c;
            tw_addr_q  <= tw_c;
          end
        end
        ISSUE: begin
          if (b_q == B_LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= D_INIT;
          end else begin
            b_q        <= issue_b_c;
            rd_addr1_q <= a1_c;
            rd_addr2_q <= a2_c;
            tw_addr_q  <= tw_c;
          end
        end
        DRAIN: begin
          if (drain_q == D_ONE) begin
            if (stage_q == S_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              stage_q    <= issue_s_c;
              b_q        <= '0;
              rd_en_q    <= 1'b1;
              rd_addr1_q <= a1_c;
              rd_addr2_q <= a2_c;
              tw_addr_q  <= tw_c;
            end
          end else begin
            drain_q <= drain_q - D_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line: the read pair re-emerges as a write BFLY_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BFLY_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{en: rd_en_q, a1: rd_addr1_q, a2: rd_addr2_q};
      for (int unsigned i = 1; i < BFLY_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.stage    = stage_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr1 = rd_addr1_q;
  assign bus.rd_addr2 = rd_addr2_q;
  assign bus.tw_addr  = tw_addr_q;
  assign bus.wr_en    = pipe_q[BFLY_LAT-1].en;
  assign bus.wr_addr1 = pipe_q[BFLY_LAT-1].a1;
  assign bus.wr_addr2 = pipe_q[BFLY_LAT-1].a2;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched: expected per-cycle trace queued at start,
// compared each cycle; two configurations (N=8/LAT=3 and N=16/LAT=1).
module tb_fft_stage_sched;

  typedef struct {
    int cyc;
    bit busy;
    bit done;
    bit rd;
    bit wr;
    int stage;
    int a1;
    int a2;
    int tw;
    int w1;
    int w2;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 0;
  exp_t q8[$];
  exp_t q16[$];
  int   busy8 = 0, done8 = 0, wr8 = 0;
  int   busy16 = 0, done16 = 0, wr16 = 0;

  fft_stage_sched_if #(.N_SAMPLES(8))  bus8 ();
  fft_stage_sched_if #(.N_SAMPLES(16)) bus16 ();

  fft_stage_sched #(.N_SAMPLES(8), .BFLY_LAT(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  fft_stage_sched #(.N_SAMPLES(16), .BFLY_LAT(1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t blank(input int c);
    exp_t e;
    e.cyc = c; e.busy = 0; e.done = 0; e.rd = 0; e.wr = 0;
    e.stage = 0; e.a1 = 0; e.a2 = 0; e.tw = 0; e.w1 = 0; e.w2 = 0;
    return e;
  endfunction

  // Build the full expected trace of one transform whose first read is in cycle base.
  task automatic gen(input int which, input int n, input int lat, input int base);
    int   ns  = $clog2(n);
    int   len = ns * (n / 2 + lat) + 1;
    int   idx = 0;
    exp_t tr[];
    tr = new[len];
    for (int i = 0; i < len; i++) tr[i] = blank(base + i);
    for (int s = 0; s < ns; s++) begin
      int half = 1 << s;
      for (int b = 0; b < n / 2; b++) begin
        tr[idx].busy  = 1;
        tr[idx].rd    = 1;
        tr[idx].stage = s;
        tr[idx].a1    = (b / half) * 2 * half + (b % half);
        tr[idx].a2    = tr[idx].a1 + half;
        tr[idx].tw    = (b % half) * ((n / 2) / half);
        idx++;
      end
      for (int d = 0; d < lat; d++) begin
        tr[idx].busy  = 1;
        tr[idx].stage = s;
        idx++;
      end
    end
    tr[idx].done = 1;
    for (int i = 0; i < len; i++) begin
      if (tr[i].rd) begin
        tr[i+lat].wr = 1;
        tr[i+lat].w1 = tr[i].a1;
        tr[i+lat].w2 = tr[i].a2;
      end
    end
    for (int i = 0; i < len; i++) begin
      if (which == 8) q8.push_back(tr[i]);
      else            q16.push_back(tr[i]);
    end
  endtask

  task automatic cmp_cycle(input string who, input exp_t e,
                           input logic busy, input logic done, input logic rd, input logic wr,
                           input logic [31:0] stage, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] tw, input logic [31:0] w1, input logic [31:0] w2);
    check({who, ".busy"},  32'(busy), 32'(e.busy));
    check({who, ".done"},  32'(done), 32'(e.done));
    check({who, ".rd_en"}, 32'(rd),   32'(e.rd));
    check({who, ".wr_en"}, 32'(wr),   32'(e.wr));
    if (e.busy) check({who, ".stage"}, stage, e.stage);
    if (e.rd) begin
      check({who, ".rd_addr1"}, a1, e.a1);
      check({who, ".rd_addr2"}, a2, e.a2);
      check({who, ".tw_addr"},  tw, e.tw);
    end
    if (e.wr) begin
      check({who, ".wr_addr1"}, w1, e.w1);
      check({who, ".wr_addr2"}, w2, e.w2);
    end
  endtask

  // Per-cycle comparison against the scoreboard; an empty slot means idle outputs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q8.size() > 0 && q8[0].cyc == cyc) e = q8.pop_front();
      else                                   e = blank(cyc);
      cmp_cycle("n8", e, bus8.busy, bus8.done, bus8.rd_en, bus8.wr_en,
                32'(bus8.stage), 32'(bus8.rd_addr1), 32'(bus8.rd_addr2),
                32'(bus8.tw_addr), 32'(bus8.wr_addr1), 32'(bus8.wr_addr2));
      if (bus8.busy)  busy8++;
      if (bus8.done)  done8++;
      if (bus8.wr_en) wr8++;

      if (q16.size() > 0 && q16[0].cyc == cyc) e = q16.pop_front();
      else                                     e = blank(cyc);
      cmp_cycle("n16", e, bus16.busy, bus16.done, bus16.rd_en, bus16.wr_en,
                32'(bus16.stage), 32'(bus16.rd_addr1), 32'(bus16.rd_addr2),
                32'(bus16.tw_addr), 32'(bus16.wr_addr1), 32'(bus16.wr_addr2));
      if (bus16.busy)  busy16++;
      if (bus16.done)  done16++;
      if (bus16.wr_en) wr16++;
    end
  end

  task automatic pulse8(output int base);
    @(posedge clk); #2;
    bus8.start = 1'b1;
    base = cyc + 1;
    gen(8, 8, 3, base);
    @(posedge clk); #2;
    bus8.start = 1'b0;
  endtask

  task automatic wait_q(input int which, input int budget);
    int k = 0;
    while (((which == 8) ? q8.size() : q16.size()) != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", (which == 8) ? q8.size() : q16.size(), 0);
    if (which == 8) q8.delete();
    else            q16.delete();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic clr8();
    busy8 = 0; done8 = 0; wr8 = 0;
  endtask

  task automatic chk_outputs_zero();
    check("rst.busy",     32'(bus8.busy),     0);
    check("rst.done",     32'(bus8.done),     0);
    check("rst.rd_en",    32'(bus8.rd_en),    0);
    check("rst.wr_en",    32'(bus8.wr_en),    0);
    check("rst.stage",    32'(bus8.stage),    0);
    check("rst.rd_addr1", 32'(bus8.rd_addr1), 0);
    check("rst.rd_addr2", 32'(bus8.rd_addr2), 0);
    check("rst.tw_addr",  32'(bus8.tw_addr),  0);
    check("rst.wr_addr1", 32'(bus8.wr_addr1), 0);
    check("rst.wr_addr2", 32'(bus8.wr_addr2), 0);
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero();
    check("rst16.busy",  32'(bus16.busy),  0);
    check("rst16.rd_en", 32'(bus16.rd_en), 0);
    check("rst16.wr_en", 32'(bus16.wr_en), 0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // Single transform, N=8 LAT=3.
    clr8();
    pulse8(base);
    wait_q(8, 100);
    check("s1.busy_cycles", busy8, 21);
    check("s1.done_pulses", done8, 1);
    check("s1.writes",      wr8,   12);

    // start re-pulsed during stage 1 must be ignored.
    clr8();
    pulse8(base);
    repeat (9) @(posedge clk);
    #2 bus8.start = 1'b1;
    @(posedge clk); #2 bus8.start = 1'b0;
    wait_q(8, 100);
    check("s2.busy_cycles", busy8, 21);
    check("s2.done_pulses", done8, 1);
    check("s2.writes",      wr8,   12);

    // Reset in stage-1 drain: outputs clear at once, in-flight writes dropped, no done.
    pulse8(base);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q8.delete();
    clr8();
    #1;
    chk_outputs_zero();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("s3.writes_after_rst", wr8,   0);
    check("s3.done_after_rst",   done8, 0);
    check("s3.busy_after_rst",   busy8, 0);
    clr8();
    pulse8(base);
    wait_q(8, 100);
    check("s3.busy_cycles", busy8, 21);
    check("s3.done_pulses", done8, 1);
    check("s3.writes",      wr8,   12);

    // N=16 LAT=1 with start held: two back-to-back transforms separated by done.
    busy16 = 0; done16 = 0; wr16 = 0;
    @(posedge clk); #2;
    bus16.start = 1'b1;
    base = cyc + 1;
    gen(16, 16, 1, base);
    gen(16, 16, 1, base + 37);
    for (int k = 0; k < 200 && cyc < base + 37; k++) @(posedge clk);
    #2 bus16.start = 1'b0;
    wait_q(16, 200);
    check("s4.busy_cycles", busy16, 72);
    check("s4.done_pulses", done16, 2);
    check("s4.writes",      wr16,   64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT over a single sample memory.
- On `start`, walks every stage and butterfly. Each cycle it issues one dual-operand read plus a twiddle ROM address to the butterfly datapath.
- Write-back to the same addresses is issued exactly BFLY_LAT cycles after each read.
- Inserts a drain gap between stages so no next-stage read overtakes a pending write. Pulses `done` when the final write has been issued.

Parameters:
- N_SAMPLES, 8, FFT length; power of two, >= 4.
- BFLY_LAT, 3, butterfly datapath latency in cycles from rd_en to matching wr_en; >= 1.
- Derived (localparam): A = $clog2(N_SAMPLES); S = A stages.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a transform; sampled only in IDLE.
- busy  output  1  high from first issue cycle through last drain cycle.
- done  output  1  one-cycle pulse after the final write-back.
- stage  output  A  stage currently issuing reads (0..S-1).
- rd_en  output  1  read strobe for rd_addr1/rd_addr2/tw_addr.
- rd_addr1  output  A  butterfly top operand address.
- rd_addr2  output  A  butterfly bottom operand address.
- tw_addr  output  A-1  twiddle ROM index (W_N^k, k = tw_addr).
- wr_en  output  1  write-back strobe.
- wr_addr1  output  A  write address for butterfly output 1.
- wr_addr2  output  A  write address for butterfly output 2.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - busy, done, rd_en, wr_en = 0.
  - stage, all addresses = 0.
  - Write pipeline fully cleared.
- Address generation, butterfly index b in 0..N/2-1, stage s:
  - half = 1<<s; group = b>>s; pos = b & (half-1).
  - rd_addr1 = group*2*half + pos.
  - rd_addr2 = rd_addr1 + half.
  - tw_addr = pos << (A-1-s).
  - All arithmetic is unsigned, truncated to the port width; no overflow is possible by construction.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE:
    - start=1 at a rising edge -> ISSUE.
    - Set b=0, stage=0.
    - rd_en=1 and busy=1 are visible in the next cycle.
  - ISSUE:
    - rd_en=1 every cycle; b increments each cycle.
    - After b=N/2-1 is issued -> DRAIN with the drain counter = BFLY_LAT.
  - DRAIN:
    - rd_en=0; busy=1; stage holds.
    - Lasts exactly BFLY_LAT cycles.
    - If stage < S-1: stage++, b=0 -> ISSUE.
    - Else -> IDLE with done=1 for one cycle (busy=0 in that cycle).
- rd_addr1/rd_addr2/tw_addr hold their last values when rd_en=0. They are don't-care for checking.
- Write pipeline:
  - Shift register of depth BFLY_LAT carrying {rd_en, rd_addr1, rd_addr2}.
  - wr_en/wr_addr1/wr_addr2 equal the rd values from BFLY_LAT cycles earlier.
  - The last write of each stage lands in that stage's final DRAIN cycle. The first read of the next stage follows one cycle later, so memory needs no write-first bypass.
- Timing:
  - Each stage occupies N/2 + BFLY_LAT cycles.
  - busy is high for S*(N/2+BFLY_LAT) cycles.
  - done pulses in the cycle after busy falls.
- Boundary conditions:
  - start while busy (ISSUE/DRAIN): ignored; no restart and no effect on addresses.
  - start high in the done cycle: accepted, since the FSM is in IDLE; the next transform begins the following cycle.
  - start held high continuously: back-to-back transforms separated only by the done cycle.
  - rst_n asserted mid-operation: immediate return to reset values. Pending in-flight writes are discarded (wr_en=0 while reset is asserted and after release). No done pulse.
  - b and stage never wrap inside a transform; both return to 0 only via IDLE->ISSUE.

Test Plan:
- N=8, BFLY_LAT=3, single start pulse -> reads, (addr1,addr2,tw) per cycle, stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0).
- Same run, stages 1 and 2:
  - Stage 1 begins after a 3-cycle rd_en=0 gap: (0,2,0)(1,3,2)(4,6,0)(5,7,2).
  - Stage 2 follows after another 3-cycle gap: (0,4,0)(1,5,1)(2,6,2)(3,7,3).
  - busy high exactly 21 cycles; done a single pulse in cycle 22.
- Write-back check:
  - Every wr_en/wr_addr pair equals the rd pair exactly 3 cycles earlier.
  - 12 writes total.
  - No read of stage s+1 occurs in or before the cycle of stage s's final write.
- start re-pulsed during stage 1 -> sequence identical to the first scenario; exactly one done.
- rst_n low for 1 cycle during stage 1 DRAIN -> all outputs 0 immediately; no further wr_en; no done; a following start produces the full first-scenario sequence from stage 0.
- N=16, BFLY_LAT=1, start held high -> stage 3 reads (0,8,0)(1,9,1)…(7,15,7); busy 4*(8+1)=36 cycles; done; a second transform's rd_en rises the cycle after done.
